// File: rtl/btn_conditioner.sv
// Push-button front end: per channel a 2-flop synchroniser, counter debouncer,
// registered press/release pulses and an optional auto-repeat generator.
module btn_conditioner #(
  parameter int                 N_BTN        = 5,
  parameter int                 DB_CYCLES    = 1_000_000,
  parameter int                 REPEAT_DELAY = 50_000_000,
  parameter int                 REPEAT_RATE  = 10_000_000,
  parameter logic [N_BTN-1:0]   REPEAT_MASK  = 5'b11110,
  parameter int                 CNT_W        = 26
) (
  input  logic             ClkPort,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {REL, DELAY, RPT} rptState_t;

  logic [N_BTN-1:0] syncMeta;
  logic [N_BTN-1:0] syncOut;
  logic [N_BTN-1:0] stableLevel;
  logic [N_BTN-1:0] dbDone;
  logic [N_BTN-1:0] acceptPress;
  logic [N_BTN-1:0] acceptRelease;
  logic [N_BTN-1:0] repeatNext;
  logic [CNT_W-1:0] dcnt     [N_BTN];
  logic [CNT_W-1:0] rcnt     [N_BTN];
  logic [CNT_W-1:0] rcntNext [N_BTN];
  rptState_t        state     [N_BTN];
  rptState_t        stateNext [N_BTN];

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= btn_raw;
      syncOut  <= syncMeta;
    end
  end

  // A change is accepted on the edge where the disagreeing run reaches DB_CYCLES.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      dbDone[i] = (syncOut[i] != stableLevel[i]) && (dcnt[i] == DB_LAST);
    end
  end

  assign acceptPress   = dbDone & syncOut;
  assign acceptRelease = dbDone & ~syncOut;
  assign btn_level     = stableLevel;

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      stableLevel <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      btn_press   <= acceptPress;
      btn_release <= acceptRelease;
      for (int i = 0; i < N_BTN; i++) begin
        if (syncOut[i] == stableLevel[i]) begin
          dcnt[i] <= '0;
        end else if (dbDone[i]) begin
          stableLevel[i] <= syncOut[i];
          dcnt[i]        <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      btn_repeat <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= REL;
        rcnt[i]  <= '0;
      end
    end else begin
      btn_repeat <= repeatNext;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= stateNext[i];
        rcnt[i]  <= rcntNext[i];
      end
    end
  end

  // Masked channels park in DELAY with the counter frozen until release.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      stateNext[i] = state[i];
      rcntNext[i]  = rcnt[i];
      if (acceptRelease[i]) begin
        stateNext[i] = REL;
        rcntNext[i]  = '0;
      end else begin
        case (state[i])
          REL: begin
            if (acceptPress[i]) begin
              stateNext[i] = DELAY;
              rcntNext[i]  = '0;
            end
          end
          DELAY: begin
            if (REPEAT_MASK[i]) begin
              if (rcnt[i] == DELAY_LAST) begin
                stateNext[i] = RPT;
                rcntNext[i]  = '0;
              end else begin
                rcntNext[i] = rcnt[i] + CNT_ONE;
              end
            end
          end
          RPT: begin
            if (rcnt[i] == RATE_LAST) begin
              rcntNext[i] = '0;
            end else begin
              rcntNext[i] = rcnt[i] + CNT_ONE;
            end
          end
          default: begin
            stateNext[i] = REL;
            rcntNext[i]  = '0;
          end
        endcase
      end
    end
  end

  // Release suppresses any repeat pulse falling in the same cycle.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      repeatNext[i] = 1'b0;
      if (!acceptRelease[i]) begin
        case (state[i])
          REL:     repeatNext[i] = acceptPress[i];
          DELAY:   repeatNext[i] = REPEAT_MASK[i] && (rcnt[i] == DELAY_LAST);
          RPT:     repeatNext[i] = (rcnt[i] == RATE_LAST);
          default: repeatNext[i] = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing, checked
// every cycle against a run-length / hold-time model of the button behaviour.
module tb_btn_conditioner;

  localparam int         N    = 2;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RR   = 3;
  localparam int         CW   = 8;
  localparam logic [1:0] MASK = 2'b01;

  logic       ClkPort = 1'b0;
  logic       Reset_n = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_repeat;

  int checks   = 0;
  int failures = 0;

  // Model: raw pipeline, disagreeing-run length, level and time since accepted press.
  logic [1:0] mP1, mS, mLvl;
  logic [1:0] expPress, expRelease, expRepeat;
  int         mRun  [N];
  int         mHeld [N];
  int         pressCnt  [N];
  int         repeatCnt [N];

  btn_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .REPEAT_MASK(MASK), .CNT_W(CW)
  ) dut (
    .ClkPort(ClkPort), .Reset_n(Reset_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic modelReset();
    mP1 = '0; mS = '0; mLvl = '0;
    expPress = '0; expRelease = '0; expRepeat = '0;
    for (int i = 0; i < N; i++) begin
      mRun[i]  = 0;
      mHeld[i] = 0;
    end
  endtask

  task automatic modelStep(input logic [1:0] raw);
    for (int i = 0; i < N; i++) begin
      logic flip;
      flip = 1'b0;
      if (mS[i] == mLvl[i]) mRun[i] = 0;
      else begin
        mRun[i]++;
        if (mRun[i] == DB) begin
          flip    = 1'b1;
          mRun[i] = 0;
        end
      end
      if (flip) mLvl[i] = ~mLvl[i];
      expPress[i]   = flip && mLvl[i];
      expRelease[i] = flip && !mLvl[i];
      if (expPress[i]) mHeld[i] = 0;
      else if (mLvl[i]) mHeld[i]++;
      expRepeat[i] = expPress[i] ||
                     (MASK[i] && mLvl[i] && mHeld[i] >= RD && ((mHeld[i] - RD) % RR) == 0);
      mS[i]  = mP1[i];
      mP1[i] = raw[i];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_level"},   btn_level,   mLvl);
    checkOutput({tag, "_press"},   btn_press,   expPress);
    checkOutput({tag, "_release"}, btn_release, expRelease);
    checkOutput({tag, "_repeat"},  btn_repeat,  expRepeat);
  endtask

  task automatic cycle(input string tag);
    @(posedge ClkPort);
    if (Reset_n) modelStep(btn_raw);
    else modelReset();
    #1;
    checkAll(tag);
    for (int i = 0; i < N; i++) begin
      pressCnt[i]  += int'(btn_press[i]);
      repeatCnt[i] += int'(btn_repeat[i]);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] raw, input int n);
    btn_raw = raw;
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic clearCounts();
    for (int i = 0; i < N; i++) begin
      pressCnt[i]  = 0;
      repeatCnt[i] = 0;
    end
  endtask

  initial begin
    int guard;
    modelReset();
    clearCounts();

    // Reset with both buttons held, then watch re-acceptance after release of reset.
    btn_raw = 2'b11;
    #1 Reset_n = 1'b0;
    #1 checkAll("t1_rst");
    applyStimulus("t1_inrst", 2'b11, 3);
    Reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle("t1_after");
      if (k == 5) checkOutput("t1_level_edge5", btn_level, 2'b00);
      if (k == 6) begin
        checkOutput("t1_level_edge6", btn_level, 2'b11);
        checkOutput("t1_press_edge6", btn_press, 2'b11);
      end
    end
    applyStimulus("t1_rel", 2'b00, 12);

    // Bounce on channel 0 then a long hold with auto-repeat.
    clearCounts();
    applyStimulus("t2_b1", 2'b01, 2);
    applyStimulus("t2_b0", 2'b00, 2);
    applyStimulus("t3_hold", 2'b01, 42);
    checkCount("t3_press_count0", pressCnt[0], 1);
    checkCount("t3_repeat_count0", repeatCnt[0], 10);

    // Time the release so it is accepted exactly when a repeat would fire.
    guard = 0;
    while (((mHeld[0] + 6 - RD) % RR) != 0 && guard < 2 * RR) begin
      cycle("t5_align");
      guard++;
    end
    checkCount("t5_align_bound", int'(guard < 2 * RR), 1);
    btn_raw = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      cycle("t5_rel");
      if (k == 6) begin
        checkOutput("t5_release0", btn_release & 2'b01, 2'b01);
        checkOutput("t5_repeat0", btn_repeat & 2'b01, 2'b00);
      end
    end
    applyStimulus("t5_idle", 2'b00, 8);

    // Channel 1 has repeat masked: only the press-coincident pulse.
    clearCounts();
    applyStimulus("t4_hold", 2'b10, 40);
    checkCount("t4_press_count1", pressCnt[1], 1);
    checkCount("t4_repeat_count1", repeatCnt[1], 1);
    applyStimulus("t4_rel", 2'b00, 10);

    // Random bouncing on both channels.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] r;
      r = btn_raw;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5) == 0) r[c] = ~r[c];
      end
      applyStimulus("rand", r, 1);
    end
    applyStimulus("rand_rel", 2'b00, 10);

    // Asynchronous reset while channel 0 sits in its delay phase.
    applyStimulus("t6_press", 2'b01, 10);
    checkOutput("t6_held_level", btn_level, 2'b01);
    #3 Reset_n = 1'b0;
    modelReset();
    #1 checkAll("t6_rst");
    applyStimulus("t6_inrst", 2'b00, 3);
    Reset_n = 1'b1;
    clearCounts();
    applyStimulus("t6_after", 2'b00, 20);
    checkCount("t6_no_press", pressCnt[0] + pressCnt[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
